fill_fwd_streamer: RTL

Turns AXI read-data beats from line fills into per-beat load-data forwards and cache write requests. Sits between the AXI R channel and the memory controller result bundle; its forward output is the `ldDataFwd` field that the load result buffer snoops to complete pending loads. It tracks one outstanding wrapping (critical-word-first) line fill per AXI ID and reconstructs each beat's address.

---
 rtl/fill_fwd_streamer_pkg.sv | 35 +++
 rtl/fill_fwd_streamer_if.sv | 40 ++++
 rtl/fill_fwd_streamer_fill_txn_table.sv | 65 ++++++
 rtl/fill_fwd_streamer.sv | 103 ++++++++++
 4 files changed

// File: rtl/fill_fwd_streamer_pkg.sv
// Shared types for the fill forward streamer: forward/cache-write beats and the per-ID fill tracker entry.
// Beat width comes from the global AXI_WIDTH macro (128-bit default).
`ifndef AXI_WIDTH
`define AXI_WIDTH 128
`endif

package fill_fwd_streamer_pkg;

  localparam int AXI_W      = `AXI_WIDTH;
  localparam int BEAT_BYTES = AXI_W / 8;
  localparam int BEAT_OFF   = $clog2(BEAT_BYTES);

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef struct packed {
    logic             valid;
    logic [31:0]      addr;
    logic [AXI_W-1:0] data;
  } LdDataFwd;

  typedef struct packed {
    logic             valid;
    logic [31:0]      addr;
    logic [AXI_W-1:0] data;
  } CacheWrite;

  // lineAddr keeps the full address with the in-line offset bits cleared
  typedef struct packed {
    logic        valid;
    logic [31:0] lineAddr;
    logic [7:0]  startBeat;
    logic [7:0]  beatCnt;
  } FillTxn;

endpackage

// File: rtl/fill_fwd_streamer_if.sv
// Bundle of the snooped AR handshake, the R channel, the forward/cache-write outputs and the error flag.
`ifndef AXI_WIDTH
`define AXI_WIDTH 128
`endif

interface fill_fwd_streamer_if #(
  parameter int ID_WIDTH = 2
);
  import fill_fwd_streamer_pkg::*;

  logic                  IN_arValid;
  logic                  IN_arReady;
  logic [ID_WIDTH-1:0]   IN_arId;
  logic [31:0]           IN_arAddr;
  logic                  IN_rValid;
  logic                  OUT_rReady;
  logic [ID_WIDTH-1:0]   IN_rId;
  logic [`AXI_WIDTH-1:0] IN_rData;
  logic                  IN_rLast;
  logic [1:0]            IN_rResp;
  LdDataFwd              OUT_ldDataFwd;
  CacheWrite             OUT_cacheW;
  logic                  IN_cacheWReady;
  logic                  OUT_err;

  modport slave (
    input  IN_arValid, IN_arReady, IN_arId, IN_arAddr,
    input  IN_rValid, IN_rId, IN_rData, IN_rLast, IN_rResp,
    input  IN_cacheWReady,
    output OUT_rReady, OUT_ldDataFwd, OUT_cacheW, OUT_err
  );

  modport master (
    output IN_arValid, IN_arReady, IN_arId, IN_arAddr,
    output IN_rValid, IN_rId, IN_rData, IN_rLast, IN_rResp,
    output IN_cacheWReady,
    input  OUT_rReady, OUT_ldDataFwd, OUT_cacheW, OUT_err
  );

endinterface

// File: rtl/fill_fwd_streamer_fill_txn_table.sv
// Per-ID wrapping line-fill tracker: allocates on AR, advances/clears on R, and generates each beat's address.
module fill_txn_table
  import fill_fwd_streamer_pkg::*;
#(
  parameter int ID_WIDTH   = 2,
  parameter int LINE_BEATS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ar_fire_i,
  input  logic [ID_WIDTH-1:0] ar_id_i,
  input  logic [31:0]         ar_addr_i,
  input  logic                r_fire_i,
  input  logic [ID_WIDTH-1:0] r_id_i,
  input  logic                r_last_i,
  output logic                hit_o,
  output logic [31:0]         beat_addr_o,
  output logic                ar_dup_o,
  output logic                last_err_o
);

  localparam int          NUM_IDS    = 1 << ID_WIDTH;
  localparam int          LINE_BYTES = LINE_BEATS * BEAT_BYTES;
  localparam logic [7:0]  BEAT_MASK  = 8'(LINE_BEATS - 1);
  localparam logic [31:0] LINE_MASK  = ~32'(LINE_BYTES - 1);

  FillTxn     ent_q [NUM_IDS];
  FillTxn     ent_d [NUM_IDS];
  FillTxn     r_ent;
  logic [7:0] beat_idx;

  assign r_ent       = ent_q[r_id_i];
  assign hit_o       = r_ent.valid;
  assign beat_idx    = (r_ent.startBeat + r_ent.beatCnt) & BEAT_MASK;
  assign beat_addr_o = r_ent.lineAddr | (32'(beat_idx) << BEAT_OFF);

  assign last_err_o = r_fire_i && r_ent.valid && (r_last_i != (r_ent.beatCnt == BEAT_MASK));

  // A last beat retiring the same ID in the same cycle frees the slot, so that AR is legal
  assign ar_dup_o = ar_fire_i && ent_q[ar_id_i].valid &&
                    !(r_fire_i && r_ent.valid && r_last_i && (r_id_i == ar_id_i));

  always_comb begin
    for (int i = 0; i < NUM_IDS; i++) ent_d[i] = ent_q[i];
    if (r_fire_i && r_ent.valid) begin
      if (r_last_i) ent_d[r_id_i] = '0;
      else          ent_d[r_id_i].beatCnt = (r_ent.beatCnt + 8'd1) & BEAT_MASK;
    end
    if (ar_fire_i) begin
      ent_d[ar_id_i].valid     = 1'b1;
      ent_d[ar_id_i].lineAddr  = ar_addr_i & LINE_MASK;
      ent_d[ar_id_i].startBeat = 8'(ar_addr_i >> BEAT_OFF) & BEAT_MASK;
      ent_d[ar_id_i].beatCnt   = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_IDS; i++) ent_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_IDS; i++) ent_q[i] <= ent_d[i];
    end
  end

endmodule

// File: rtl/fill_fwd_streamer.sv
// Turns AXI R line-fill beats into one-cycle load-data forwards and held cache-write beats.
// Optional FILL_ERR_CHECK_EN enables the sticky protocol error flag and drops bad beats.
`ifndef AXI_WIDTH
`define AXI_WIDTH 128
`endif

module fill_fwd_streamer
  import fill_fwd_streamer_pkg::*;
#(
  parameter int ID_WIDTH   = 2,
  parameter int LINE_BEATS = 4
) (
  input logic                 clk,
  input logic                 rst,
  fill_fwd_streamer_if.slave  bus
);

  logic             ar_fire;
  logic             r_fire;
  logic             hit;
  logic             keep;
  logic [31:0]      beat_addr;
  logic             ar_dup;
  logic             last_err;
  logic             cw_vld_q, cw_vld_d;
  logic             fwd_vld_q, fwd_vld_d;
  logic [31:0]      addr_q;
  logic [AXI_W-1:0] data_q;

  assign ar_fire        = bus.IN_arValid && bus.IN_arReady;
  assign bus.OUT_rReady = !cw_vld_q || bus.IN_cacheWReady;
  assign r_fire         = bus.IN_rValid && bus.OUT_rReady;

  fill_txn_table #(
    .ID_WIDTH   (ID_WIDTH),
    .LINE_BEATS (LINE_BEATS)
  ) u_table (
    .clk         (clk),
    .rst         (rst),
    .ar_fire_i   (ar_fire),
    .ar_id_i     (bus.IN_arId),
    .ar_addr_i   (bus.IN_arAddr),
    .r_fire_i    (r_fire),
    .r_id_i      (bus.IN_rId),
    .r_last_i    (bus.IN_rLast),
    .hit_o       (hit),
    .beat_addr_o (beat_addr),
    .ar_dup_o    (ar_dup),
    .last_err_o  (last_err)
  );

`ifdef FILL_ERR_CHECK_EN
  logic err_q, err_d;

  assign keep = hit && (bus.IN_rResp == AXI_RESP_OKAY);
  assign err_d = err_q || ar_dup || last_err ||
                 (r_fire && (!hit || (bus.IN_rResp != AXI_RESP_OKAY)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  assign bus.OUT_err = err_q;
`else
  logic unused_chk;

  assign keep        = hit;
  assign unused_chk  = ^{bus.IN_rResp, ar_dup, last_err};
  assign bus.OUT_err = 1'b0;
`endif

  // An accepted beat always finds the output slot free or draining this cycle
  always_comb begin
    cw_vld_d  = cw_vld_q && !bus.IN_cacheWReady;
    fwd_vld_d = 1'b0;
    if (r_fire) begin
      cw_vld_d  = keep;
      fwd_vld_d = keep;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cw_vld_q  <= 1'b0;
      fwd_vld_q <= 1'b0;
    end else begin
      cw_vld_q  <= cw_vld_d;
      fwd_vld_q <= fwd_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (r_fire && keep) begin
      addr_q <= beat_addr;
      data_q <= bus.IN_rData;
    end
  end

  assign bus.OUT_cacheW    = '{valid: cw_vld_q,  addr: addr_q, data: data_q};
  assign bus.OUT_ldDataFwd = '{valid: fwd_vld_q, addr: addr_q, data: data_q};

endmodule
